// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory arbiter: FSM state codes,
// owner encoding, byte-lane selectors and the address range check.
package dmem_pkg;

  localparam int DEPTH_DEF = 100;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WR_HI = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  // A 16-bit word occupies addr and addr+1, so the last legal word address is depth-2.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr + 32'd2) <= 32'(depth);
  endfunction

  // One byte of a big-endian word, zero-extended to the memory write bus.
  function automatic logic [15:0] lane_word(input logic [15:0] w, input logic lane);
    return {8'h00, (lane == HI) ? w[15:8] : w[7:0]};
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle: one instance per port of the arbiter.
interface dmem_req_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-grant history is kept by the caller.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_gnt,
  output logic gnt_a,
  output logic gnt_b
);

  // On a tie the port that was not served last wins.
  assign gnt_a = req_a & (~req_b | (last_gnt == OWN_B));
  assign gnt_b = req_b & ~gnt_a;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a byte-wide data memory between two 16-bit requesters; stores are
// split into two big-endian byte writes, loads are one registered access.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  dmem_req_if.slave     a,
  dmem_req_if.slave     b,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  logic [2:0]    state;
  logic          owner_q;
  logic          err_q;
  logic          last_gnt;
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          gnt_a;
  logic          gnt_b;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_err;

  rr_arb2 u_arb (
    .req_a    (a.req),
    .req_b    (b.req),
    .last_gnt (last_gnt),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b)
  );

  always_comb begin
    win_we    = gnt_b ? b.we    : a.we;
    win_addr  = gnt_b ? b.addr  : a.addr;
    win_wdata = gnt_b ? b.wdata : a.wdata;
    win_err   = ~addr_ok(32'(win_addr), DEPTH);
  end

  // Control: state, ownership, round-robin history and the per-port read registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner_q   <= OWN_A;
      err_q     <= 1'b0;
      last_gnt  <= OWN_B;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_a | gnt_b) begin
            owner_q <= gnt_b ? OWN_B : OWN_A;
            err_q   <= win_err;
            if (win_err) begin
              state <= S_ACK;
              // A rejected access reports zero data rather than a stale word.
              if (gnt_b) b_rdata_q <= '0;
              else       a_rdata_q <= '0;
            end else begin
              state <= win_we ? S_WR_HI : S_RD;
            end
          end
        end
        S_RD: begin
          if (owner_q == OWN_B) b_rdata_q <= m_rdata;
          else                  a_rdata_q <= m_rdata;
          state <= S_ACK;
        end
        S_WR_HI: state <= S_WR_LO;
        S_WR_LO: state <= S_ACK;
        S_ACK: begin
          last_gnt <= owner_q;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Transaction payload is only consumed while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && (gnt_a | gnt_b)) begin
      addr_q  <= win_addr;
      wdata_q <= win_wdata;
    end
  end

  // Memory bus is a pure decode of registered state; requests never reach it directly.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    case (state)
      S_RD: m_addr = addr_q;
      S_WR_HI: begin
        m_addr  = addr_q;
        m_wdata = DW'(lane_word(wdata_q[15:0], HI));
        m_we    = 1'b1;
      end
      S_WR_LO: begin
        m_addr  = addr_q + AW'(1);
        m_wdata = DW'(lane_word(wdata_q[15:0], LO));
        m_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  assign a.ack   = (state == S_ACK) && (owner_q == OWN_A);
  assign b.ack   = (state == S_ACK) && (owner_q == OWN_B);
  assign a.err   = a.ack & err_q;
  assign b.err   = b.ack & err_q;
  assign a.rdata = a_rdata_q;
  assign b.rdata = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory model, per-cycle scoreboard and directed scenarios.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int DEPTH = 100;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_req_if #(.AW(AW), .DW(DW)) ia ();
  dmem_req_if #(.AW(AW), .DW(DW)) ib ();

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_we;
  logic          busy;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (ia),
    .b       (ib),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_we    (m_we),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0: return 8'h3C;
      1: return 8'hAD;
      4: return 8'h14;
      5: return 8'h63;
      6: return 8'hDA;
      7: return 8'hED;
      8: return 8'hFE;
      9: return 8'hEB;
      default: return 8'h00;
    endcase
  endfunction

  // Physical memory driven by the DUT bus; reinitialised by the same reset.
  logic [7:0]  mem [DEPTH];
  logic [23:0] wlog [$];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = init_byte(i);
    end else if (m_we) begin
      wlog.push_back({m_addr, m_wdata[7:0]});
      if (int'(m_addr) < DEPTH) mem[int'(m_addr)] = m_wdata[7:0];
    end
  end

  logic [7:0] rd_hi, rd_lo;
  always_comb begin
    rd_hi = 8'h00;
    rd_lo = 8'h00;
    if (int'(m_addr) < DEPTH)     rd_hi = mem[int'(m_addr)];
    if (int'(m_addr) + 1 < DEPTH) rd_lo = mem[int'(m_addr) + 1];
    m_rdata = {rd_hi, rd_lo};
  end

  // Reference contents: what each word must hold after every acknowledged store.
  logic [7:0] mdl [DEPTH];
  function automatic logic [15:0] mdl_word(input int adr);
    return {mdl[adr], mdl[adr+1]};
  endfunction

  int            wcnt = 0;
  int            wexp = 0;
  logic [DW-1:0] pa = '0;
  logic [DW-1:0] pb = '0;

  task automatic port_mon(input string n, input logic req, input logic we, input logic ack,
                          input logic err, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rdata, input logic [DW-1:0] prev);
    logic bad;
    if (ack) begin
      bad = (int'(addr) > DEPTH - 2);
      chk({n, "_ack_without_req"}, 32'(req), 32'd1);
      chk({n, "_err"}, 32'(err), 32'(bad));
      if (bad) chk({n, "_err_rdata"}, 32'(rdata), 32'd0);
      else if (!we) chk({n, "_load_rdata"}, 32'(rdata), 32'(mdl_word(int'(addr))));
      else begin
        mdl[int'(addr)]     = wdata[15:8];
        mdl[int'(addr) + 1] = wdata[7:0];
        wexp += 2;
      end
    end else begin
      chk({n, "_rdata_held"}, 32'(rdata), 32'(prev));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = init_byte(i);
      wcnt = 0;
      wexp = 0;
    end else begin
      chk("both_acks", 32'(ia.ack & ib.ack), 32'd0);
      port_mon("a", ia.req, ia.we, ia.ack, ia.err, ia.addr, ia.wdata, ia.rdata, pa);
      port_mon("b", ib.req, ib.we, ib.ack, ib.err, ib.addr, ib.wdata, ib.rdata, pb);
      if (m_we) begin
        wcnt++;
        chk("we_while_idle", 32'(busy), 32'd1);
        chk("wdata_upper", 32'(m_wdata[15:8]), 32'd0);
      end
      if (!busy) begin
        chk("idle_we", 32'(m_we), 32'd0);
        chk("idle_addr", 32'(m_addr), 32'd0);
      end
    end
    pa = ia.rdata;
    pb = ib.rdata;
  end

  // One requester transaction, starting just after a clock edge; returns just after
  // the edge that ends the ack cycle with req dropped (caller may re-raise it at once).
  task automatic issue(input bit p, input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd,
                       output logic er, output logic [7:0] bv);
    logic ack;
    lat = 0;
    bv  = '0;
    if (!p) begin ia.req = 1'b1; ia.we = we; ia.addr = adr; ia.wdata = wd; end
    else    begin ib.req = 1'b1; ib.we = we; ib.addr = adr; ib.wdata = wd; end
    bv[0] = busy;
    ack = p ? ib.ack : ia.ack;
    while (!ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 8) bv[lat] = busy;
      ack = p ? ib.ack : ia.ack;
    end
    chk("ack_seen", 32'(ack), 32'd1);
    rd = p ? ib.rdata : ia.rdata;
    er = p ? ib.err : ia.err;
    @(posedge clk); #1;
    if (!p) ia.req = 1'b0;
    else    ib.req = 1'b0;
  endtask

  int            lat, lat2, latb, w0;
  logic [DW-1:0] rd, rd2, rdb;
  logic          er, er2, erb;
  logic [7:0]    bv, bv2, bvb;

  initial begin
    ia.req = 1'b0; ia.we = 1'b0; ia.addr = '0; ia.wdata = '0;
    ib.req = 1'b0; ib.we = 1'b0; ib.addr = '0; ib.wdata = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wdata", 32'(m_wdata), 32'd0);
    chk("rst_acks", 32'({ia.ack, ib.ack}), 32'd0);
    chk("rst_errs", 32'({ia.err, ib.err}), 32'd0);
    chk("rst_rdata", {ia.rdata, ib.rdata}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single load from A.
    w0 = wcnt;
    issue(1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, er, bv);
    chk("ld0_latency", 32'(lat), 32'd2);
    chk("ld0_rdata", 32'(rd), 32'h3CAD);
    chk("ld0_err", 32'(er), 32'd0);
    chk("ld0_busy_profile", 32'(bv), 32'h06);
    chk("ld0_no_writes", 32'(wcnt - w0), 32'd0);

    // Store then read back; byte order on the bus is big-endian.
    wlog.delete();
    issue(1'b0, 1'b1, 16'h0002, 16'hBEEF, lat, rd, er, bv);
    chk("st_latency", 32'(lat), 32'd3);
    chk("st_err", 32'(er), 32'd0);
    chk("st_write_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("st_write_hi", 32'(wlog[0]), 32'h0002BE);
      chk("st_write_lo", 32'(wlog[1]), 32'h0003EF);
    end
    issue(1'b0, 1'b0, 16'h0002, 16'h0000, lat, rd, er, bv);
    chk("rb_latency", 32'(lat), 32'd2);
    chk("rb_rdata", 32'(rd), 32'hBEEF);

    // Tie straight after reset goes to A; A's back-to-back request then ties with
    // the waiting B, which now wins.
    rst = 1'b0;
    #10;
    rst = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        issue(1'b0, 1'b0, 16'h0004, 16'h0000, lat, rd, er, bv);
        issue(1'b0, 1'b0, 16'h0008, 16'h0000, lat2, rd2, er2, bv2);
      end
      issue(1'b1, 1'b0, 16'h0006, 16'h0000, latb, rdb, erb, bvb);
    join
    chk("tie_a_latency", 32'(lat), 32'd2);
    chk("tie_a_rdata", 32'(rd), 32'h1463);
    chk("tie_b_latency", 32'(latb), 32'd5);
    chk("tie_b_rdata", 32'(rdb), 32'hDAED);
    chk("tie2_a_latency", 32'(lat2), 32'd5);
    chk("tie2_a_rdata", 32'(rd2), 32'hFEEB);

    // Out-of-range accesses from B.
    w0 = wcnt;
    issue(1'b1, 1'b0, 16'h0063, 16'h0000, lat, rd, er, bv);
    chk("oor_ld_latency", 32'(lat), 32'd1);
    chk("oor_ld_err", 32'(er), 32'd1);
    chk("oor_ld_rdata", 32'(rd), 32'd0);
    chk("oor_ld_busy_profile", 32'(bv), 32'h02);
    issue(1'b1, 1'b1, 16'h00FF, 16'h1234, lat, rd, er, bv);
    chk("oor_st_latency", 32'(lat), 32'd1);
    chk("oor_st_err", 32'(er), 32'd1);
    chk("oor_no_writes", 32'(wcnt - w0), 32'd0);
    issue(1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, er, bv);
    chk("oor_mem_intact", 32'(rd), 32'h3CAD);
    chk("total_writes", 32'(wcnt), 32'(wexp));

    // Reset lands in the middle of a store.
    ia.req = 1'b1; ia.we = 1'b1; ia.addr = 16'h0010; ia.wdata = 16'hA55A;
    @(posedge clk); #1;
    chk("mid_hi_we", 32'(m_we), 32'd1);
    chk("mid_hi_addr", 32'(m_addr), 32'h0010);
    chk("mid_hi_wdata", 32'(m_wdata), 32'h00A5);
    @(posedge clk); #1;
    chk("mid_lo_addr", 32'(m_addr), 32'h0011);
    chk("mid_lo_wdata", 32'(m_wdata), 32'h005A);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(m_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_acks", 32'({ia.ack, ib.ack}), 32'd0);
    chk("mid_rst_addr", 32'(m_addr), 32'd0);
    ia.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 16'h0008, 16'h0000, lat, rd, er, bv);
    chk("post_rst_latency", 32'(lat), 32'd2);
    chk("post_rst_rdata", 32'(rd), 32'hFEEB);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Sequences and shares the byte-organised data memory between two requesters: port A (pipeline MEM stage) and port B (debug/loader). Each 16-bit store becomes two byte writes, big-endian: high byte at addr, low byte at addr+1. Each 16-bit read is one memory access with a registered result. Sits between the MEM stage/debug port and the data memory; the memory's address, write-data and write-enable are driven only by this block.

Parameters:
DEPTH, 100, data memory size in bytes; legal word address range is 0..DEPTH-2.
AW, 16, address width.
DW, 16, requester data width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_ack
a_we  in  1  port A: 1 = store, 0 = load
a_addr  in  AW  port A byte address
a_wdata  in  DW  port A store data
a_ack  out  1  port A one-cycle completion pulse
a_rdata  out  DW  port A load data, valid while a_ack is high and held afterwards
a_err  out  1  port A out-of-range flag, valid with a_ack
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err  same as the port A signals, for port B
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data: {8'h00, byte}; the memory stores bits [7:0]
m_we  out  1  memory write enable
m_rdata  in  DW  memory combinational read data {Data[m_addr], Data[m_addr+1]}
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous), effective immediately:
  - state=IDLE; m_we=0; m_addr=0; m_wdata=0.
  - a_ack=b_ack=0; a_err=b_err=0; a_rdata=b_rdata=0.
  - last_gnt=B, so A wins the first tie.
- Reset during a store after WR_HI leaves a half-written word. The memory reinitialises on the same reset, so this is acceptable.
- States: IDLE, RD, WR_HI, WR_LO, ACK.
- IDLE:
  - If any req is high, pick the winner and latch owner, we, addr and wdata into internal registers.
  - Next state: if addr > DEPTH-2, go to ACK with err=1. Otherwise go to RD if we=0, or WR_HI if we=1.
  - Outputs: m_we=0, m_addr=0.
- RD: m_addr=addr_q. At the clock edge, the owner's rdata register <= m_rdata. Next state ACK.
- WR_HI: m_addr=addr_q, m_wdata={8'h00,wdata_q[15:8]}, m_we=1. Next state WR_LO.
- WR_LO: m_addr=addr_q+1 (AW-bit), m_wdata={8'h00,wdata_q[7:0]}, m_we=1. Next state ACK.
- ACK:
  - The owner's ack is high for exactly this cycle, and its err reflects the range check.
  - Error transactions write nothing and leave the owner's rdata at 0.
  - last_gnt <= owner. Next state IDLE.
- Latency (req to ack): load 2 cycles; store 3 cycles; out-of-range 1 cycle.
- Handshake:
  - Requester samples ack at the rising edge.
  - It must change or deassert req/controls in the cycle after ack.
  - A req still high in the IDLE cycle after ACK is a new transaction (back-to-back allowed).
  - Minimum spacing: 1 idle cycle between transactions.
- Arbitration: only evaluated in IDLE.
  - If one req is high, grant it.
  - If both are high, grant the port that is not last_gnt (round-robin).
  - A losing requester keeps req high and waits; no request is dropped.
- Non-owner ack is never asserted. Non-owner rdata is unchanged by another port's transaction.
- m_we is a pure decode of the state register: no combinational path from req to m_we or m_addr.
- Address arithmetic: addr+1 is computed in AW bits; an addr of 0xFFFF is already rejected by the range check.

Decomposition:
- Package dmem_pkg: state enum (IDLE, RD, WR_HI, WR_LO, ACK), owner encoding (OWN_A=0, OWN_B=1), DEPTH default, byte-lane constants HI/LO.
- One sub-module, rr_arb2: 2-way round-robin with inputs req_a, req_b, last_gnt and outputs gnt_a, gnt_b. Purely combinational; the last_gnt register lives in dmem_arbiter.

Test Plan:
- Reset, then a load from A at addr 0x0000 -> a_ack pulses at cycle 2, a_rdata=0x3CAD, a_err=0, m_we never high, busy high for cycles 1-2.
- A stores 0xBEEF at addr 0x0002 -> m_we high for 2 cycles (m_addr 0x0002 with data 0x00BE, then 0x0003 with data 0x00EF); a_ack at cycle 3. A then loads addr 0x0002 -> a_rdata=0xBEEF.
- A and B both assert load requests (A addr 0x0004, B addr 0x0006) in the same cycle after reset -> A is served first (a_rdata=0x1463), then B (b_rdata=0xDAED). Next tie -> B is served first.
- B loads addr 0x0063 (DEPTH-1) -> b_ack at cycle 1 with b_err=1, b_rdata=0, no m_we.
- B stores to addr 0x00FF -> b_err=1, and memory content at addr 0x0000 still reads 0x3CAD.
- Assert rst low during WR_LO of a store -> m_we=0 and busy=0 immediately, all acks 0. After release, A loads addr 0x0008 -> 0xFEEB.
